// File: rtl/ram_nb_8w_pkg.sv
// ram_nb_8w_pkg: shared geometry and address decode for the 8-word RAM
package ram_nb_8w_pkg;

    localparam int unsigned NWORDS = 8;
    localparam int unsigned AW     = 3;

    // One-hot write select for the addressed word
    function automatic logic [NWORDS-1:0] dec_sel(input logic [AW-1:0] a);
        dec_sel    = '0;
        dec_sel[a] = 1'b1;
    endfunction

endpackage

// File: rtl/ram_byte_8w.sv
// ram_byte_8w: one 8-bit by 8-word slice with active-low write and output enables
module ram_byte_8w
    import ram_nb_8w_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] A,
    input  logic [7:0]    DIN,
    input  logic          WR,
    input  logic          OE,
    output logic [7:0]    DOUT
);

    logic [NWORDS-1:0][7:0] mem_q;
    logic [NWORDS-1:0][7:0] mem_d;
    logic [NWORDS-1:0]      sel;

    // Next array state: only the addressed word takes DIN when WR is low
    always_comb begin
        sel = dec_sel(A);
        for (int k = 0; k < NWORDS; k++)
            mem_d[k] = (!WR && sel[k]) ? DIN : mem_q[k];
    end

    // Array storage; reset clears every word without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign DOUT = OE ? 8'h00 : mem_q[A];

endmodule

// File: rtl/ram_nb_8w.sv
// ram_nb_8w: 8-word by NBYTES-byte RAM built from per-byte slices
module ram_nb_8w
    import ram_nb_8w_pkg::*;
#(
    parameter int unsigned NBYTES = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       A,
    input  logic [8*NBYTES-1:0] DIN,
    input  logic                WR,
    input  logic                OE,
    output logic [8*NBYTES-1:0] DOUT
);

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        ram_byte_8w u_slice (
            .clk  (clk),
            .rst_n(rst_n),
            .A    (A),
            .DIN  (DIN[8*i +: 8]),
            .WR   (WR),
            .OE   (OE),
            .DOUT (DOUT[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_ram_nb_8w.sv
// tb_ram_nb_8w: directed checks of the 8-word RAM at NBYTES=32 and NBYTES=1
`timescale 1ns/100ps
module tb_ram_nb_8w;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   a = 3'd0;
    logic [W-1:0] din = '0;
    logic         wr = 1'b1;
    logic         oe = 1'b0;
    logic [W-1:0] dout;

    logic [2:0]   a1 = 3'd0;
    logic [7:0]   din1 = 8'h00;
    logic         wr1 = 1'b1;
    logic         oe1 = 1'b0;
    logic [7:0]   dout1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_nb_8w #(.NBYTES(32)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .DIN(din), .WR(wr), .OE(oe), .DOUT(dout)
    );

    ram_nb_8w #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .DIN(din1), .WR(wr1), .OE(oe1), .DOUT(dout1)
    );

    function automatic logic [W-1:0] pat(input int k);
        logic [W-1:0] p;
        for (int b = 0; b < 32; b++) p[8*b +: 8] = 8'(k*16 + b);
        return p;
    endfunction

    task automatic wr_word(input logic [2:0] addr, input logic [W-1:0] d);
        @(negedge clk);
        a = addr; din = d; wr = 1'b0;
        @(posedge clk); #1;
        wr = 1'b1;
    endtask

    task automatic test_reset();
        oe = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = 3'(k); #0.5;
            tests++;
            if (dout !== '0) begin fails++; $display("FAIL reset_hold a=%0d got=%h exp=0", k, dout); end
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 8; k++) wr_word(3'(k), {32{8'hA5}});
        @(negedge clk); a = 3'd6; #0.5;
        tests++;
        if (dout !== {32{8'hA5}}) begin fails++; $display("FAIL prefill got=%h exp=%h", dout, {32{8'hA5}}); end
        @(negedge clk); #1; rst_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = 3'(k); #0.4;
            tests++;
            if (dout !== '0) begin fails++; $display("FAIL async_clear a=%0d got=%h exp=0", k, dout); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wr_inactive();
        @(negedge clk);
        a = 3'd5; wr = 1'b1; din = {16{16'hDEAD}};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); din = ~din;
        end
        #0.5;
        tests++;
        if (dout !== '0) begin fails++; $display("FAIL wr_inactive got=%h exp=0", dout); end
    endtask

    task automatic test_write_read_all();
        for (int k = 0; k < 8; k++) wr_word(3'(k), pat(k));
        @(negedge clk); oe = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = 3'(k); #0.5;
            tests++;
            if (dout !== pat(k)) begin fails++; $display("FAIL rw_all a=%0d got=%h exp=%h", k, dout, pat(k)); end
        end
    endtask

    task automatic test_oe_no_write_through();
        wr_word(3'd3, '1);
        @(negedge clk);
        a = 3'd3; oe = 1'b1; #0.5;
        tests++;
        if (dout !== '0) begin fails++; $display("FAIL oe_high got=%h exp=0", dout); end
        oe = 1'b0; #0.5;
        tests++;
        if (dout !== '1) begin fails++; $display("FAIL oe_low got=%h exp=all-ones", dout); end
        din = W'(16'h1234); wr = 1'b0; #0.5;
        tests++;
        if (dout !== '1) begin fails++; $display("FAIL no_write_through got=%h exp=all-ones", dout); end
        @(posedge clk); #1;
        wr = 1'b1;
        tests++;
        if (dout !== W'(16'h1234)) begin fails++; $display("FAIL write_visible got=%h exp=1234", dout); end
        a = 3'd4; #0.5;
        tests++;
        if (dout !== pat(4)) begin fails++; $display("FAIL neighbour a=4 got=%h exp=%h", dout, pat(4)); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a = 3'd1; wr = 1'b0; din = {32{8'h11}};
        @(negedge clk); din = {32{8'h22}};
        @(negedge clk); wr = 1'b1; #0.5;
        tests++;
        if (dout !== {32{8'h22}}) begin fails++; $display("FAIL back_to_back got=%h exp=%h", dout, {32{8'h22}}); end
    endtask

    task automatic test_reset_write();
        @(negedge clk);
        rst_n = 1'b0; a = 3'd2; din = '1; wr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        wr = 1'b1; rst_n = 1'b1; #0.5;
        tests++;
        if (dout !== '0) begin fails++; $display("FAIL reset_drops_write got=%h exp=0", dout); end
        a = 3'd7; #0.5;
        tests++;
        if (dout !== '0) begin fails++; $display("FAIL reset_clears_a7 got=%h exp=0", dout); end
        wr_word(3'd2, {32{8'h5A}});
        a = 3'd2; #0.5;
        tests++;
        if (dout !== {32{8'h5A}}) begin fails++; $display("FAIL post_reset_write got=%h exp=%h", dout, {32{8'h5A}}); end
    endtask

    task automatic test_param();
        @(negedge clk); a1 = 3'd7; din1 = 8'h3C; wr1 = 1'b0;
        @(negedge clk); a1 = 3'd0; din1 = 8'hC3;
        @(negedge clk); wr1 = 1'b1; oe1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] exp;
            exp = (k == 7) ? 8'h3C : (k == 0) ? 8'hC3 : 8'h00;
            a1 = 3'(k); #0.5;
            tests++;
            if (dout1 !== exp) begin fails++; $display("FAIL param_nb1 a=%0d got=%h exp=%h", k, dout1, exp); end
        end
        oe1 = 1'b1; a1 = 3'd7; #0.5;
        tests++;
        if (dout1 !== 8'h00) begin fails++; $display("FAIL param_oe got=%h exp=00", dout1); end
    endtask

    initial begin
        #12;
        test_reset();
        test_wr_inactive();
        test_write_read_all();
        test_oe_no_write_through();
        test_back_to_back();
        test_reset_write();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/ram_nb_8w.md
# ram_nb_8w

Eight-word by N-byte random-access memory, 256 bits per word by default. It is the storage primitive under the instruction-cache data store; two instances form the 16-line, 32-byte-per-line array. Writes are synchronous with active-low write enable. Reads are combinational, gated by an active-low output enable. Contents clear on reset.

## Interface
Parameters:
- `NBYTES`, default 32: bytes per word; data width W = 8*NBYTES.

Ports:
- `clk`  in  1: single clock; writes occur on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low; clears every word.
- `A`  in  3: word address, 0..7.
- `DIN`  in  W: write data.
- `WR`  in  1: write enable, active-low (0 = write).
- `OE`  in  1: output enable, active-low (0 = drive stored word).
- `DOUT`  out  W: read data.

## Operation
- Storage: 8 words of W bits, no byte enables; a write updates the full word.
- Write: on a rising edge of `clk`, if `rst_n`=1 and `WR`=0, `mem[A]` <= `DIN`. All other words are unchanged.
- `WR`=1 leaves the array unchanged.
- Read: `DOUT` = `mem[A]` when `OE`=0, and all-zero when `OE`=1.
  - `DOUT` is always driven; there are no tri-states.
  - The read is purely combinational from `A`, `OE` and array contents.
- Reset: while `rst_n`=0, all 8 words are forced to 0 and writes are ignored. With `OE`=0, `DOUT` reads 0 during reset.
- Addresses: `A` is exactly 3 bits, so every value is legal and there is no wrap or out-of-range case.
- X on `A` while `WR`=0 is illegal stimulus. The bench must not generate it.

## Timing
- Write latency: data written at edge k is visible on `DOUT` combinationally just after edge k.
- No write-through: in the cycle before the edge, `DOUT` shows the old contents of `mem[A]`, even when A equals the write address.
- Read latency: zero cycles. `DOUT` follows changes on `A` or `OE` within the same cycle.
- Back-to-back writes to the same address: the last edge wins.
- Write to one address while reading another: the read shows the unaffected word.
- Reset assertion mid-operation:
  - Clears the array immediately, with no clock needed.
  - A write whose edge coincides with `rst_n`=0 is dropped.
- Reset deassertion: the first write takes effect on the first rising edge with `rst_n`=1.

## Structure
- No shared package is needed. `NBYTES` is the only constant.
- One sub-module is natural: `ram_byte_8w`, an 8-bit by 8-word slice with the same ports at 8-bit width.
  - The top instantiates NBYTES slices by generate.
  - All slices share `A`, `WR`, `OE`, `clk` and `rst_n`.
  - Each slice takes byte i of `DIN` and drives byte i of `DOUT`.
- Address decode (3-to-8 one-hot write select) and the per-word read mux live in the slice.

## Test plan
- Reset clear:
  - Stimulus: write 0xA5 repeated to all 8 words, then pulse `rst_n` low asynchronously between clock edges.
  - Required response: with `OE`=0, every A = 0..7 reads 0, and does so before the next edge.
- Write/read all words:
  - Stimulus: at A=k write a pattern with each byte = k*16+byte_index.
  - Required response: read back all 8 words with `OE`=0, each exact; no cross-word corruption.
- Output enable and no write-through:
  - Stimulus: first, with `OE`=1 and A=3 holding 0xFF..FF, check `DOUT`. Then, with `WR`=0, A=3, DIN=0x1234 zero-extended, check `DOUT` before and after the edge.
  - Required response: `DOUT`=0 while `OE`=1. Before the edge it shows 0xFF..FF; after the edge it shows 0x1234.
- WR inactive:
  - Stimulus: `WR`=1 with DIN=0xDEAD.. toggled every cycle for 4 edges at A=5, which holds 0.
  - Required response: A=5 still reads 0.
- Simultaneous reset and write:
  - Stimulus: drive `rst_n`=0 across an edge with `WR`=0, A=2, DIN=all-ones.
  - Required response: after release, A=2 reads 0. A write on the next edge then stores its data.
- Parameter check:
  - Stimulus: NBYTES=1; write 0x3C to A=7 and 0xC3 to A=0.
  - Required response: reads return those values, and A=1..6 read 0.
